multicycle_controller: RTL and testbench

Sequencing controller that turns the single-cycle datapath into a multicycle MIPS core by sharing one ALU and one unified instruction/data memory across several clock cycles per instruction. Sits beside the datapath: takes the opcode from the instruction register and a memory-ready handshake, and drives every mux select and write enable. It also keeps a retired-instruction counter for debug and performance.

---
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller.sv | 68 ++++++
 tb/tb_multicycle_controller.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control bundle between the multicycle controller and its datapath.
// Inputs to the controller: opcode (IR[31:26]), mem_ready (memory completes this cycle).
// Outputs: pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite, memtoreg, regdst,
// alusrca, alusrcb[1:0], aluop[1:0], pcsource[1:0], state[3:0], retire, illegal, instr_count[31:0].
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic mem_ready;
    logic pcwrite;
    logic pcwritecond;
    logic iord;
    logic memread;
    logic memwrite;
    logic irwrite;
    logic regwrite;
    logic memtoreg;
    logic regdst;
    logic alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic [3:0] state;
    logic retire;
    logic illegal;
    logic [31:0] instr_count;
    modport master (
        input opcode, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite, memtoreg, regdst,
        output alusrca, alusrcb, aluop, pcsource, state, retire, illegal, instr_count
    );
    modport slave (
        output opcode, mem_ready,
        input pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite, memtoreg, regdst,
        input alusrca, alusrcb, aluop, pcsource, state, retire, illegal, instr_count
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS sequencer driving datapath selects/strobes, with retired-instruction counter.
// Ports: clk, rst (async active-high), bus (multicycle_controller_if.master).
// ADDI_INSTRUCTION_EN: when defined, opcode 001000 runs DECODE -> ADDI_EX -> ADDI_WB; otherwise it is illegal.
module multicycle_controller (
    input logic clk,
    input logic rst,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3, MEM_WB = 4'd4, MEM_WRITE = 4'd5,
        EXECUTE = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDI_EX = 4'd10, ADDI_WB = 4'd11
    } state_t;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
`ifdef ADDI_INSTRUCTION_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif
    state_t st;
    state_t dec;
    logic [3:0] s;
    // Decoding from an unused encoding while in reset zeroes every strobe and select at once.
    assign s = rst ? 4'hf : st;
    always_comb begin
        dec = bus.opcode == OP_R ? EXECUTE :
              (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEM_ADDR :
              bus.opcode == OP_BEQ ? BRANCH :
              bus.opcode == OP_J ? JUMP :
              (ADDI_EN && bus.opcode == OP_ADDI) ? ADDI_EX : FETCH;
        bus.state = st;
        bus.memread = s == FETCH || s == MEM_READ;
        bus.irwrite = s == FETCH && bus.mem_ready;
        bus.pcwrite = (s == FETCH && bus.mem_ready) || s == JUMP;
        bus.pcwritecond = s == BRANCH;
        bus.memwrite = s == MEM_WRITE;
        bus.regwrite = s inside {MEM_WB, R_WB, ADDI_WB};
        bus.iord = s inside {MEM_READ, MEM_WRITE};
        bus.memtoreg = s == MEM_WB;
        bus.regdst = s == R_WB;
        bus.alusrca = s inside {MEM_ADDR, EXECUTE, BRANCH, ADDI_EX};
        bus.alusrcb = s == DECODE ? 2'b11 : s inside {MEM_ADDR, ADDI_EX} ? 2'b10 : s == FETCH ? 2'b01 : 2'b00;
        bus.aluop = s == EXECUTE ? 2'b10 : s == BRANCH ? 2'b01 : 2'b00;
        bus.pcsource = s == JUMP ? 2'b10 : s == BRANCH ? 2'b01 : 2'b00;
        bus.retire = s inside {MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB} || (s == MEM_WRITE && bus.mem_ready);
        bus.illegal = s == DECODE && dec == FETCH;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= FETCH;
            bus.instr_count <= 32'd0;
        end else begin
            if (bus.retire) bus.instr_count <= bus.instr_count + 32'd1;
            case (st)
                FETCH: if (bus.mem_ready) st <= DECODE;
                DECODE: st <= dec;
                MEM_ADDR: st <= bus.opcode == OP_SW ? MEM_WRITE : MEM_READ;
                MEM_READ: if (bus.mem_ready) st <= MEM_WB;
                MEM_WRITE: if (bus.mem_ready) st <= FETCH;
                EXECUTE: st <= R_WB;
`ifdef ADDI_INSTRUCTION_EN
                ADDI_EX: st <= ADDI_WB;
`endif
                default: st <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic [3:0] st_tr [32];
    logic [17:0] out_tr [32];
    int n_tr;
    multicycle_controller_if ifc ();
    multicycle_controller dut (.clk(clk), .rst(rst), .bus(ifc));
    always #5 clk = ~clk;
    // {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite, memtoreg, regdst, alusrca,
    //  alusrcb[1:0], aluop[1:0], pcsource[1:0], retire, illegal}
    localparam logic [17:0] V_F   = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] V_D   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] V_DI  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
    localparam logic [17:0] V_MA  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] V_MR  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] V_MWB = 18'b0_0_0_0_0_0_1_1_0_0_00_00_00_1_0;
    localparam logic [17:0] V_EX  = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] V_RWB = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [17:0] V_BR  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [17:0] V_J   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
`ifdef ADDI_INSTRUCTION_EN
    localparam logic [17:0] V_AE  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] V_AW  = 18'b0_0_0_0_0_0_1_0_0_0_00_00_00_1_0;
`endif
    function automatic logic [17:0] outs();
        return {ifc.pcwrite, ifc.pcwritecond, ifc.iord, ifc.memread, ifc.memwrite, ifc.irwrite,
                ifc.regwrite, ifc.memtoreg, ifc.regdst, ifc.alusrca, ifc.alusrcb, ifc.aluop,
                ifc.pcsource, ifc.retire, ifc.illegal};
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // Runs one instruction from FETCH with mem_ready held high, tracing state and outputs per cycle.
    task automatic run(input logic [5:0] op, output int cyc, output int ret);
        cyc = 0;
        ret = 0;
        n_tr = 0;
        ifc.opcode = op;
        ifc.mem_ready = 1'b1;
        #1;
        do begin
            st_tr[n_tr] = ifc.state;
            out_tr[n_tr] = outs();
            n_tr++;
            ret += int'(ifc.retire);
            cyc++;
            step();
        end while (ifc.state != 4'd0 && cyc < 20);
    endtask
    task automatic test_reset();
        checks++;
        if (ifc.state !== 4'd0 || ifc.instr_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_state state=%0d count=%0h want 0/0", ifc.state, ifc.instr_count);
        end
        checks++;
        if (outs() !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want 0", outs());
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ifc.state !== 4'd0 || outs() !== V_F) begin
            failures++;
            $display("FAIL reset_release state=%0d outs=%b want 0/%b", ifc.state, outs(), V_F);
        end
    endtask
    task automatic test_seq(input string name, input logic [5:0] op, input int n_exp,
                            input logic [3:0] s_exp [8], input logic [17:0] o_exp [8], input int r_exp);
        int cyc, ret;
        run(op, cyc, ret);
        exp_cnt = exp_cnt + 32'(r_exp);
        checks++;
        if (cyc !== n_exp || ret !== r_exp) begin
            failures++;
            $display("FAIL %s_cycles cycles=%0d retires=%0d want %0d/%0d", name, cyc, ret, n_exp, r_exp);
        end
        for (int i = 0; i < n_exp && i < n_tr; i++) begin
            checks++;
            if (st_tr[i] !== s_exp[i] || out_tr[i] !== o_exp[i]) begin
                failures++;
                $display("FAIL %s_cycle%0d state=%0d outs=%b want %0d/%b", name, i, st_tr[i], out_tr[i], s_exp[i], o_exp[i]);
            end
        end
        checks++;
        if (ifc.instr_count !== exp_cnt) begin
            failures++;
            $display("FAIL %s_count got=%0h want %0h", name, ifc.instr_count, exp_cnt);
        end
    endtask
    task automatic test_lw();
        test_seq("lw", 6'b100011, 5, '{0, 1, 2, 3, 4, 0, 0, 0}, '{V_F, V_D, V_MA, V_MR, V_MWB, 0, 0, 0}, 1);
    endtask
    task automatic test_r_type();
        test_seq("rtype", 6'b000000, 4, '{0, 1, 6, 7, 0, 0, 0, 0}, '{V_F, V_D, V_EX, V_RWB, 0, 0, 0, 0}, 1);
    endtask
    task automatic test_beq_j();
        test_seq("beq", 6'b000100, 3, '{0, 1, 8, 0, 0, 0, 0, 0}, '{V_F, V_D, V_BR, 0, 0, 0, 0, 0}, 1);
        test_seq("j", 6'b000010, 3, '{0, 1, 9, 0, 0, 0, 0, 0}, '{V_F, V_D, V_J, 0, 0, 0, 0, 0}, 1);
    endtask
    task automatic test_illegal();
        test_seq("illegal", 6'b111111, 2, '{0, 1, 0, 0, 0, 0, 0, 0}, '{V_F, V_DI, 0, 0, 0, 0, 0, 0}, 0);
    endtask
    task automatic test_sw_stall();
        logic rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] se [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5};
        int mw = 0;
        int ret = 0;
        ifc.opcode = 6'b101011;
        for (int i = 0; i < 6; i++) begin
            ifc.mem_ready = rdy[i];
            #1;
            checks++;
            if (ifc.state !== se[i]) begin
                failures++;
                $display("FAIL sw_cycle%0d state=%0d want %0d", i, ifc.state, se[i]);
            end
            mw += int'(ifc.memwrite);
            ret += int'(ifc.retire);
            step();
        end
        exp_cnt = exp_cnt + 32'd1;
        checks++;
        if (mw !== 3 || ret !== 1 || ifc.state !== 4'd0) begin
            failures++;
            $display("FAIL sw_stall memwrite_cycles=%0d retires=%0d end_state=%0d want 3/1/0", mw, ret, ifc.state);
        end
        checks++;
        if (ifc.instr_count !== exp_cnt) begin
            failures++;
            $display("FAIL sw_count got=%0h want %0h", ifc.instr_count, exp_cnt);
        end
        ifc.mem_ready = 1'b1;
    endtask
    task automatic test_mid_reset();
        ifc.opcode = 6'b100011;
        ifc.mem_ready = 1'b1;
        repeat (3) step();
        ifc.mem_ready = 1'b0;
        step();
        checks++;
        if (ifc.state !== 4'd3 || ifc.memread !== 1'b1 || ifc.instr_count === 32'd0) begin
            failures++;
            $display("FAIL stall_mem_read state=%0d memread=%b count=%0h want 3/1/nonzero", ifc.state, ifc.memread, ifc.instr_count);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.state !== 4'd0 || ifc.instr_count !== 32'd0 || outs() !== 18'd0) begin
            failures++;
            $display("FAIL mid_reset state=%0d count=%0h outs=%b want 0/0/0", ifc.state, ifc.instr_count, outs());
        end
        exp_cnt = 32'd0;
        ifc.mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ifc.state !== 4'd0 || ifc.memread !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_release state=%0d memread=%b want 0/1", ifc.state, ifc.memread);
        end
    endtask
    task automatic test_wrap();
        force ifc.instr_count = 32'hffff_ffff;
        #1;
        release ifc.instr_count;
        exp_cnt = 32'hffff_ffff;
        test_r_type();
    endtask
    task automatic test_addi();
`ifdef ADDI_INSTRUCTION_EN
        test_seq("addi", 6'b001000, 4, '{0, 1, 10, 11, 0, 0, 0, 0}, '{V_F, V_D, V_AE, V_AW, 0, 0, 0, 0}, 1);
`else
        test_seq("addi", 6'b001000, 2, '{0, 1, 0, 0, 0, 0, 0, 0}, '{V_F, V_DI, 0, 0, 0, 0, 0, 0}, 0);
`endif
    endtask
    initial begin
        ifc.opcode = 6'd0;
        ifc.mem_ready = 1'b1;
        #12;
        test_reset();
        test_lw();
        test_sw_stall();
        test_r_type();
        test_beq_j();
        test_illegal();
        test_mid_reset();
        test_wrap();
        test_addi();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
